ex_unit_pipe: RTL
=================

# ex_unit_pipe

Registered, parametrised integer execute unit for the out-of-order core. It sits between the reservation-station issue port and the common data bus (CDB) arbiter. It accepts one operation per handshake and computes ALU, branch-compare and jump-target results for all RV32I type codes in the shared instruction-type defines. The result is held in an output register until the CDB accepts it. Optionally it adds an iterative multiplier.

## Interface
Parameters:
- XLEN, 32, datapath width; must be a power of two, ≥ 8.
- TAG_W, 4, ROB tag width carried alongside each operation.
- TYPE_W, 6, width of the instruction-type code (matches `INST_TYPE_WIDTH`).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of in-flight and held work (mispredict).
- in_valid  in  1  issue request.
- in_ready  out  1  unit can accept this cycle.
- in_type  in  TYPE_W  instruction-type code.
- in_vj, in_vk  in  XLEN  source operands.
- in_a  in  XLEN  immediate.
- in_pc  in  XLEN  instruction PC.
- in_tag  in  TAG_W  ROB tag.
- out_valid  out  1  result held for CDB.
- out_ready  in  1  CDB accepts.
- out_value  out  XLEN  result, link address, or branch condition (0/1).
- out_jumppc  out  XLEN  target for JALR and branches, else 0.
- out_tag  out  TAG_W  tag of the held result.

## Operation
- Issue is accepted on `in_valid && in_ready`. Output is retired on `out_valid && out_ready`.
- FSM states:
  - IDLE → RES on accept of a single-cycle type.
  - IDLE → MUL on accept of a MUL-class type (macro only).
  - MUL → RES when the iteration count reaches XLEN.
  - RES → IDLE on retire with no same-cycle accept. RES → RES on retire with a same-cycle accept (back-to-back).
- in_ready = (state==IDLE) || (state==RES && out_ready).
- Arithmetic wraps modulo 2^XLEN. Signed compares use two's complement.
- Shift amount = low log2(XLEN) bits of vk (R-type) or of A (I-type). SRA/SRAI are arithmetic.
- LUI: value = A. AUIPC: value = pc+A.
- JAL: value = pc+4, jumppc = 0.
- JALR: value = pc+4, jumppc = (vj+A) & ~1.
- Branches (BEQ/BNE/BLT/BGE/BLTU/BGEU): value = condition (1/0), jumppc = pc+A.
- Unrecognised type: value = 0, jumppc = 0, still retired with its tag.
- flush:
  - forces IDLE and clears out_valid next edge; in_ready is 0 in the flush cycle.
  - beats flush-cycle accept and retire: neither takes effect.
- Outputs are registered; no combinational path from in_* to out_*. in_ready depends combinationally on out_ready.

## Timing
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - out_valid=0, out_value=0, out_jumppc=0, out_tag=0.
  - Multiplier counter and accumulator = 0.
- Reset mid-MUL discards the operation.
- Single-cycle op latency: accept at edge N → out_valid=1 after edge N. Sustained throughput is 1 op/cycle while out_ready=1.
- MUL latency: accept at edge N → out_valid after edge N+XLEN. in_ready=0 throughout.
- Backpressure: out_value, out_jumppc and out_tag stay stable while out_valid && !out_ready.

## Configuration
- EX_UNIT_MUL_EN defined:
  - MUL, MULH, MULHSU and MULHU are accepted.
  - They run as a radix-2 shift-add over XLEN cycles with a 2·XLEN accumulator. Signed operands are handled by magnitude and sign fix-up.
  - MUL returns the low XLEN bits; the MULH variants return the high XLEN bits.
- Not defined:
  - MUL state and logic are absent.
  - MUL-class types are treated as unrecognised: value 0, single-cycle.

## Test plan
- Reset then idle: out_valid=0, in_ready=1. Issue ADD vj=0xFFFFFFFF vk=1 tag=3 → next cycle out_value=0, out_tag=3.
- Back-to-back with out_ready=1: SRA vj=0x80000000 vk=0x24 then SLTU vj=1 vk=0xFFFFFFFF → 0xF8000000 then 1 on consecutive cycles.
- Stall: JALR vj=0x1003 A=4 pc=0x200 with out_ready=0 for 3 cycles → value=0x204, jumppc=0x1006 held stable; in_ready=0 until retire.
- Branch: BLT vj=0xFFFFFFFE vk=1 pc=0x100 A=0x20 → value=1, jumppc=0x120. BGEU with the same operands → value=1.
- flush on the same edge as a retire of a held BEQ → out_valid=0 next cycle and no second retire.
- EX_UNIT_MUL_EN: MULH vj=0xFFFFFFFF vk=2 → out_valid exactly 32 cycles after accept with value=0xFFFFFFFF; MULHU with the same operands → 1.

Source files
------------

// File: rtl/ex_unit_pipe.sv
// Registered integer execute unit between RS issue and the CDB: ALU, branch compare, jump target.
// Define EX_UNIT_MUL_EN to add an iterative shift-add multiplier (MUL/MULH/MULHSU/MULHU).
module ex_unit_pipe #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned TYPE_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [TYPE_W-1:0] in_type_i,
    input  logic [XLEN-1:0]   in_vj_i,
    input  logic [XLEN-1:0]   in_vk_i,
    input  logic [XLEN-1:0]   in_a_i,
    input  logic [XLEN-1:0]   in_pc_i,
    input  logic [TAG_W-1:0]  in_tag_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [XLEN-1:0]   out_value_o,
    output logic [XLEN-1:0]   out_jumppc_o,
    output logic [TAG_W-1:0]  out_tag_o
);

    localparam int unsigned ShW = $clog2(XLEN);

    // Instruction-type codes; 0 and anything unlisted is unrecognised.
    localparam logic [TYPE_W-1:0] TyAdd   = TYPE_W'(1),  TySub   = TYPE_W'(2);
    localparam logic [TYPE_W-1:0] TySll   = TYPE_W'(3),  TySlt   = TYPE_W'(4);
    localparam logic [TYPE_W-1:0] TySltu  = TYPE_W'(5),  TyXor   = TYPE_W'(6);
    localparam logic [TYPE_W-1:0] TySrl   = TYPE_W'(7),  TySra   = TYPE_W'(8);
    localparam logic [TYPE_W-1:0] TyOr    = TYPE_W'(9),  TyAnd   = TYPE_W'(10);
    localparam logic [TYPE_W-1:0] TyAddi  = TYPE_W'(11), TySlti  = TYPE_W'(12);
    localparam logic [TYPE_W-1:0] TySltiu = TYPE_W'(13), TyXori  = TYPE_W'(14);
    localparam logic [TYPE_W-1:0] TyOri   = TYPE_W'(15), TyAndi  = TYPE_W'(16);
    localparam logic [TYPE_W-1:0] TySlli  = TYPE_W'(17), TySrli  = TYPE_W'(18);
    localparam logic [TYPE_W-1:0] TySrai  = TYPE_W'(19), TyLui   = TYPE_W'(20);
    localparam logic [TYPE_W-1:0] TyAuipc = TYPE_W'(21), TyJal   = TYPE_W'(22);
    localparam logic [TYPE_W-1:0] TyJalr  = TYPE_W'(23), TyBeq   = TYPE_W'(24);
    localparam logic [TYPE_W-1:0] TyBne   = TYPE_W'(25), TyBlt   = TYPE_W'(26);
    localparam logic [TYPE_W-1:0] TyBge   = TYPE_W'(27), TyBltu  = TYPE_W'(28);
    localparam logic [TYPE_W-1:0] TyBgeu  = TYPE_W'(29);
`ifdef EX_UNIT_MUL_EN
    localparam logic [TYPE_W-1:0] TyMul   = TYPE_W'(30), TyMulh  = TYPE_W'(31);
    localparam logic [TYPE_W-1:0] TyMulhsu = TYPE_W'(32), TyMulhu = TYPE_W'(33);

    typedef enum logic [1:0] {StIdle, StRes, StMul} state_e;
`else
    typedef enum logic [1:0] {StIdle, StRes} state_e;
`endif

    state_e             state_q;
    logic               out_valid_q;
    logic [XLEN-1:0]    out_value_q, out_jumppc_q;
    logic [TAG_W-1:0]   out_tag_q;
    logic [XLEN-1:0]    alu_val, alu_jmp;
    logic [ShW-1:0]     sh_r, sh_i;
    logic               accept;

    assign in_ready_o   = !flush_i && (state_q == StIdle || (state_q == StRes && out_ready_i));
    assign accept       = in_valid_i && in_ready_o;
    assign out_valid_o  = out_valid_q;
    assign out_value_o  = out_value_q;
    assign out_jumppc_o = out_jumppc_q;
    assign out_tag_o    = out_tag_q;

    always_comb begin
        sh_r    = in_vk_i[ShW-1:0];
        sh_i    = in_a_i[ShW-1:0];
        alu_val = '0;
        alu_jmp = '0;
        case (in_type_i)
            TyAdd:   alu_val = in_vj_i + in_vk_i;
            TySub:   alu_val = in_vj_i - in_vk_i;
            TySll:   alu_val = in_vj_i << sh_r;
            TySlt:   alu_val = XLEN'($signed(in_vj_i) < $signed(in_vk_i));
            TySltu:  alu_val = XLEN'(in_vj_i < in_vk_i);
            TyXor:   alu_val = in_vj_i ^ in_vk_i;
            TySrl:   alu_val = in_vj_i >> sh_r;
            TySra:   alu_val = $unsigned($signed(in_vj_i) >>> sh_r);
            TyOr:    alu_val = in_vj_i | in_vk_i;
            TyAnd:   alu_val = in_vj_i & in_vk_i;
            TyAddi:  alu_val = in_vj_i + in_a_i;
            TySlti:  alu_val = XLEN'($signed(in_vj_i) < $signed(in_a_i));
            TySltiu: alu_val = XLEN'(in_vj_i < in_a_i);
            TyXori:  alu_val = in_vj_i ^ in_a_i;
            TyOri:   alu_val = in_vj_i | in_a_i;
            TyAndi:  alu_val = in_vj_i & in_a_i;
            TySlli:  alu_val = in_vj_i << sh_i;
            TySrli:  alu_val = in_vj_i >> sh_i;
            TySrai:  alu_val = $unsigned($signed(in_vj_i) >>> sh_i);
            TyLui:   alu_val = in_a_i;
            TyAuipc: alu_val = in_pc_i + in_a_i;
            TyJal:   alu_val = in_pc_i + XLEN'(4);
            TyJalr: begin
                alu_val = in_pc_i + XLEN'(4);
                alu_jmp = (in_vj_i + in_a_i) & ~XLEN'(1);
            end
            TyBeq, TyBne, TyBlt, TyBge, TyBltu, TyBgeu: begin
                alu_jmp = in_pc_i + in_a_i;
                case (in_type_i)
                    TyBeq:   alu_val = XLEN'(in_vj_i == in_vk_i);
                    TyBne:   alu_val = XLEN'(in_vj_i != in_vk_i);
                    TyBlt:   alu_val = XLEN'($signed(in_vj_i) < $signed(in_vk_i));
                    TyBge:   alu_val = XLEN'($signed(in_vj_i) >= $signed(in_vk_i));
                    TyBltu:  alu_val = XLEN'(in_vj_i < in_vk_i);
                    default: alu_val = XLEN'(in_vj_i >= in_vk_i);
                endcase
            end
            default: ;
        endcase
    end

`ifdef EX_UNIT_MUL_EN
    logic [ShW:0]        mul_cnt_q;
    logic [2*XLEN-1:0]   mul_acc_q;
    logic [XLEN-1:0]     mul_mcand_q;
    logic                mul_neg_q, mul_hi_q;
    logic                is_mul, a_neg, b_neg;
    logic [XLEN-1:0]     mag_a, mag_b, mul_res;
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_step, mul_prod;

    always_comb begin
        is_mul = (in_type_i == TyMul) || (in_type_i == TyMulh) ||
                 (in_type_i == TyMulhsu) || (in_type_i == TyMulhu);
        a_neg  = (in_type_i == TyMulh || in_type_i == TyMulhsu) && in_vj_i[XLEN-1];
        b_neg  = (in_type_i == TyMulh) && in_vk_i[XLEN-1];
        mag_a  = a_neg ? -in_vj_i : in_vj_i;
        mag_b  = b_neg ? -in_vk_i : in_vk_i;
        // Multiplier sits in the low half and shifts out as the partial product grows.
        mul_sum  = {1'b0, mul_acc_q[2*XLEN-1:XLEN]} +
                   (mul_acc_q[0] ? {1'b0, mul_mcand_q} : '0);
        mul_step = {mul_sum, mul_acc_q[XLEN-1:1]};
        mul_prod = mul_neg_q ? -mul_step : mul_step;
        mul_res  = mul_hi_q ? mul_prod[2*XLEN-1:XLEN] : mul_prod[XLEN-1:0];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            out_valid_q  <= 1'b0;
            out_value_q  <= '0;
            out_jumppc_q <= '0;
            out_tag_q    <= '0;
`ifdef EX_UNIT_MUL_EN
            mul_cnt_q    <= '0;
            mul_acc_q    <= '0;
            mul_mcand_q  <= '0;
            mul_neg_q    <= 1'b0;
            mul_hi_q     <= 1'b0;
`endif
        end else if (flush_i) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_tag_q <= in_tag_i;
`ifdef EX_UNIT_MUL_EN
            if (is_mul) begin
                state_q     <= StMul;
                out_valid_q <= 1'b0;
                mul_cnt_q   <= '0;
                mul_acc_q   <= {{XLEN{1'b0}}, mag_b};
                mul_mcand_q <= mag_a;
                mul_neg_q   <= a_neg ^ b_neg;
                mul_hi_q    <= (in_type_i != TyMul);
            end else
`endif
            begin
                state_q      <= StRes;
                out_valid_q  <= 1'b1;
                out_value_q  <= alu_val;
                out_jumppc_q <= alu_jmp;
            end
        end else if (state_q == StRes && out_ready_i) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
        end
`ifdef EX_UNIT_MUL_EN
        else if (state_q == StMul) begin
            mul_cnt_q <= mul_cnt_q + 1'b1;
            mul_acc_q <= mul_step;
            // Final iteration folds the sign fix-up straight into the output register.
            if (mul_cnt_q == (ShW+1)'(XLEN-1)) begin
                state_q      <= StRes;
                out_valid_q  <= 1'b1;
                out_value_q  <= mul_res;
                out_jumppc_q <= '0;
            end
        end
`endif
    end

endmodule
